multicycle_ctrl: RTL

//  Multi-cycle control FSM for the Cessar RV32 core subset LW/SW/BEQ/R-type (ADD,SUB,AND,OR,SLT).

---
 rtl/multicycle_ctrl_pkg.sv | 127 ++++++++++++
 rtl/multicycle_ctrl_alu_decoder.sv | 35 +++
 rtl/multicycle_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
//   Shared constants for the Cessar RV32 multi-cycle control slice: opcodes,
//   FSM state codes, ALU control codes, immediate formats and datapath mux
//   selects. The immediate generator and ALU are meant to import the same
//   package so encodings cannot drift apart.
//   Also provides ctrl_for_state(), the Moore output table of the FSM.
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

  // FSM states; the numeric codes are visible on the debug port state_o
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXEC      = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    TRAP      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] IMM_NONE = 2'b00;
  localparam logic [1:0] IMM_I    = 2'b01;
  localparam logic [1:0] IMM_S    = 2'b10;
  localparam logic [1:0] IMM_B    = 2'b11;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  // Registered (Moore) control fields; ir_write and pc_write are Mealy and
  // live outside this bundle
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctl;
    logic [1:0] imm_sel;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  // Moore output table: what the datapath sees while sitting in state s.
  // is_store picks the S immediate in MEM_ADDR, exec_ctl is the decoded
  // R-type operation for EXEC. Anything not listed stays 0.
  function automatic ctrl_t ctrl_for_state(input state_e s,
                                           input logic is_store,
                                           input logic [3:0] exec_ctl);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_a = SRC_A_PC;
        c.alu_src_b = SRC_B_FOUR;
        c.alu_ctl   = ALU_ADD;
      end
      DECODE: begin
        c.alu_src_a = SRC_A_OLDPC;
        c.alu_src_b = SRC_B_IMM;
        c.alu_ctl   = ALU_ADD;
        c.imm_sel   = IMM_B;
      end
      MEM_ADDR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_ctl   = ALU_ADD;
        c.imm_sel   = is_store ? IMM_S : IMM_I;
      end
      MEM_READ: begin
        c.mem_req = 1'b1;
        c.i_or_d  = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.i_or_d  = 1'b1;
      end
      EXEC: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_ctl   = exec_ctl;
      end
      ALU_WB: begin
        c.reg_write = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_ctl   = ALU_SUB;
        c.pc_src    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_alu_decoder
//   Combinational R-type function decode. Maps {funct3, funct7[5]} to the ALU
//   control code and flags whether the combination is one the core supports.
// Ports
//   funct3_i    in  3  IR[14:12]
//   funct7_5_i  in  1  IR[30]
//   alu_ctl_o   out 4  ALU operation (0 when not legal)
//   legal_o     out 1  1 = ADD/SUB/SLT/OR/AND
// ---------------------------------------------------------------------------
module multicycle_ctrl_alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_ctl_o,
  output logic       legal_o
);

  // funct7[5] only distinguishes ADD from SUB; with any other funct3 it
  // must be 0 or the encoding is outside the supported subset
  always_comb begin
    alu_ctl_o = ALU_AND;
    legal_o   = 1'b1;
    case ({funct3_i, funct7_5_i})
      4'b000_0: alu_ctl_o = ALU_ADD;
      4'b000_1: alu_ctl_o = ALU_SUB;
      4'b010_0: alu_ctl_o = ALU_SLT;
      4'b110_0: alu_ctl_o = ALU_OR;
      4'b111_0: alu_ctl_o = ALU_AND;
      default:  legal_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle control FSM for the Cessar RV32 subset LW/SW/BEQ/R-type.
//   Drives every datapath mux/enable, handshakes with the unified memory and
//   traps on illegal instructions or a memory that never answers.
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   opcode_i/funct3_i/funct7_5_i   instruction fields from IR
//   zero_i                 ALU zero flag (BEQ outcome)
//   mem_ready_i            memory acknowledge
//   mem_req_o, mem_we_o, i_or_d_o       memory request, write, address mux
//   ir_write_o, pc_write_o, pc_src_o    IR/PC load controls
//   alu_src_a_o, alu_src_b_o, alu_ctl_o ALU operand selects and operation
//   imm_sel_o              immediate format
//   reg_write_o, mem_to_reg_o           register writeback controls
//   err_illegal_o, err_timeout_o        sticky trap causes
//   state_o                current state code (debug)
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       i_or_d_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       pc_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [3:0] alu_ctl_o,
  output logic [1:0] imm_sel_o,
  output logic       reg_write_o,
  output logic       mem_to_reg_o,
  output logic       err_illegal_o,
  output logic       err_timeout_o,
  output logic [3:0] state_o
);

  // Last permitted count value; one more waiting cycle from here is a timeout
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             err_illegal_q, err_timeout_q;
  logic             set_illegal, set_timeout;
  logic             mem_state;
  logic             is_store;
  logic [3:0]       exec_ctl;
  logic             rtype_legal;

  multicycle_ctrl_alu_decoder u_alu_decoder (
    .funct3_i   (funct3_i),
    .funct7_5_i (funct7_5_i),
    .alu_ctl_o  (exec_ctl),
    .legal_o    (rtype_legal)
  );

  assign is_store = (opcode_i == OP_STORE);

  // Next-state and wait-counter logic. The counter is zero whenever the FSM
  // is not waiting, so every memory state is entered with a cleared count.
  // The timeout override comes after the case so it wins over "stay", but
  // it only fires when mem_ready is low: a ready on the last cycle advances.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    mem_state   = (state_q == FETCH) || (state_q == MEM_READ) ||
                  (state_q == MEM_WRITE);
    case (state_q)
      IDLE:      state_d = FETCH;
      FETCH:     if (mem_ready_i) state_d = DECODE;
      DECODE: begin
        case (opcode_i)
          OP_LOAD, OP_STORE: begin
            if (funct3_i == F3_WORD) state_d = MEM_ADDR;
            else                     set_illegal = 1'b1;
          end
          OP_BRANCH: begin
            if (funct3_i == F3_BEQ) state_d = BRANCH;
            else                    set_illegal = 1'b1;
          end
          OP_RTYPE: begin
            if (rtype_legal) state_d = EXEC;
            else             set_illegal = 1'b1;
          end
          default: set_illegal = 1'b1;
        endcase
        if (set_illegal) state_d = TRAP;
      end
      MEM_ADDR:  state_d = is_store ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (mem_ready_i) state_d = MEM_WB;
      MEM_WB:    state_d = FETCH;
      MEM_WRITE: if (mem_ready_i) state_d = FETCH;
      EXEC:      state_d = ALU_WB;
      ALU_WB:    state_d = FETCH;
      BRANCH:    state_d = FETCH;
      TRAP:      state_d = TRAP;
      default:   state_d = IDLE;
    endcase
    if (mem_state && !mem_ready_i) begin
      if (cnt_q == CNT_LAST) begin
        state_d     = TRAP;
        set_timeout = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    ctrl_d = ctrl_for_state(state_d, is_store, exec_ctl);
  end

  // State, counter, registered outputs and sticky error flags. Outputs are
  // computed for the state being entered, so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ctrl_q        <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ctrl_q        <= ctrl_d;
      err_illegal_q <= err_illegal_q | set_illegal;
      err_timeout_q <= err_timeout_q | set_timeout;
    end
  end

  // IR/PC loads must follow the same-cycle acknowledge / branch outcome,
  // so these two are decoded from the live inputs rather than registered
  assign ir_write_o = (state_q == FETCH) && mem_ready_i;
  assign pc_write_o = ((state_q == FETCH) && mem_ready_i) ||
                      ((state_q == BRANCH) && zero_i);

  assign mem_req_o     = ctrl_q.mem_req;
  assign mem_we_o      = ctrl_q.mem_we;
  assign i_or_d_o      = ctrl_q.i_or_d;
  assign pc_src_o      = ctrl_q.pc_src;
  assign alu_src_a_o   = ctrl_q.alu_src_a;
  assign alu_src_b_o   = ctrl_q.alu_src_b;
  assign alu_ctl_o     = ctrl_q.alu_ctl;
  assign imm_sel_o     = ctrl_q.imm_sel;
  assign reg_write_o   = ctrl_q.reg_write;
  assign mem_to_reg_o  = ctrl_q.mem_to_reg;
  assign err_illegal_o = err_illegal_q;
  assign err_timeout_o = err_timeout_q;
  assign state_o       = state_q;

endmodule
